// File: rtl/sensor_conditioner_if.sv
// Signal bundle between the raw sensor front end and the home-automation controller.
// The master drives the raw contacts and ADC samples; the slave (conditioner) returns the clean sensor set.
interface sensor_conditioner_if;
  logic       raw_fd;
  logic       raw_rd;
  logic       raw_w;
  logic       raw_fa;
  logic [6:0] st_raw;
  logic       st_vld;
  logic       SFD;
  logic       SRD;
  logic       SW;
  logic       SFA;
  logic [6:0] ST;
  logic       st_ready;

  modport master (
    output raw_fd, raw_rd, raw_w, raw_fa, st_raw, st_vld,
    input  SFD, SRD, SW, SFA, ST, st_ready
  );

  modport slave (
    input  raw_fd, raw_rd, raw_w, raw_fa, st_raw, st_vld,
    output SFD, SRD, SW, SFA, ST, st_ready
  );
endinterface

// File: rtl/sensor_conditioner.sv
// Sensor input stage: 2-FF sync plus debounce for door/window/fire contacts,
// moving-average filter for the ADC temperature word.
module sensor_conditioner #(
    parameter int         DEB_CYCLES = 16,
    parameter int         FA_CYCLES  = 4,
    parameter int         AVG_LOG2   = 2,
    parameter logic [6:0] ST_RST     = 7'd25
) (
    input logic                 Clk,
    input logic                 Rst,
    sensor_conditioner_if.slave bus
);

    // Contact order: 0 front door, 1 rear door, 2 window, 3 fire alarm.
    logic [3:0] raw_vec;
    assign raw_vec = {bus.raw_fa, bus.raw_w, bus.raw_rd, bus.raw_fd};

    for (genvar g = 0; g < 4; g++) begin : g_deb
        localparam int N  = (g == 3) ? FA_CYCLES : DEB_CYCLES;
        localparam int CW = $clog2(N);
        localparam logic [CW-1:0] LAST = CW'(N - 1);

        logic [1:0]    sync;
        logic [CW-1:0] cnt;
        logic          q;

        // Output flips only after sync[1] has disagreed with q for N sampled cycles in a row.
        always_ff @(posedge Clk or negedge Rst) begin
            if (!Rst) begin
                sync <= '0;
                cnt  <= '0;
                q    <= 1'b0;
            end else begin
                sync <= {sync[0], raw_vec[g]};
                if (sync[1] == q) begin
                    cnt <= '0;
                end else if (cnt == LAST) begin
                    q   <= sync[1];
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

    assign bus.SFD = g_deb[0].q;
    assign bus.SRD = g_deb[1].q;
    assign bus.SW  = g_deb[2].q;
    assign bus.SFA = g_deb[3].q;

    // Handshake: st_vld is a one-cycle strobe with no back-pressure, every strobe is
    // absorbed; st_ready is a status flag that rises once the first sample primed the window.
    localparam int W    = 1 << AVG_LOG2;
    localparam int SUMW = 7 + AVG_LOG2;

    logic [6:0]      taps [W];
    logic [SUMW-1:0] sum;
    logic [SUMW-1:0] new_sum;
    logic            prime;

    // The sum always covers exactly the taps, so subtracting the oldest tap never underflows.
    always_comb begin
        new_sum = sum + SUMW'(bus.st_raw) - SUMW'(taps[W-1]);
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            for (int i = 0; i < W; i++) taps[i] <= '0;
            sum          <= '0;
            prime        <= 1'b0;
            bus.st_ready <= 1'b0;
            bus.ST       <= ST_RST;
        end else if (bus.st_vld) begin
            if (!prime) begin
                // First sample fills the whole window so the average starts at that value.
                for (int i = 0; i < W; i++) taps[i] <= bus.st_raw;
                sum          <= SUMW'(bus.st_raw) << AVG_LOG2;
                bus.ST       <= bus.st_raw;
                prime        <= 1'b1;
                bus.st_ready <= 1'b1;
            end else begin
                taps[0] <= bus.st_raw;
                for (int i = 1; i < W; i++) taps[i] <= taps[i-1];
                sum    <= new_sum;
                bus.ST <= 7'(new_sum >> AVG_LOG2);
            end
        end
    end

endmodule

// File: tb/tb_sensor_conditioner.sv
// Bench for sensor_conditioner: debounce latency/glitch/reset checks and a
// scoreboard-checked moving average on the temperature path.
module tb_sensor_conditioner;
  localparam int DEB      = 16;
  localparam int FA       = 4;
  localparam int AVG_LOG2 = 2;
  localparam int W        = 1 << AVG_LOG2;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sensor_conditioner_if ifc ();

  sensor_conditioner #(
    .DEB_CYCLES(DEB),
    .FA_CYCLES (FA),
    .AVG_LOG2  (AVG_LOG2),
    .ST_RST    (7'd25)
  ) dut (
    .Clk(clk),
    .Rst(rst_n),
    .bus(ifc.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [6:0] exp_q[$];
  int         mdl_taps[W];
  bit         mdl_prime = 1'b0;
  logic       vld_at_edge = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_temp(input logic [6:0] v);
    int s;
    ifc.st_raw = v;
    ifc.st_vld = 1'b1;
    if (!mdl_prime) begin
      for (int i = 0; i < W; i++) mdl_taps[i] = int'(v);
      mdl_prime = 1'b1;
    end else begin
      for (int i = W - 1; i > 0; i--) mdl_taps[i] = mdl_taps[i-1];
      mdl_taps[0] = int'(v);
    end
    s = 0;
    for (int i = 0; i < W; i++) s += mdl_taps[i];
    exp_q.push_back(7'(s / W));
    tick();
    ifc.st_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // scoreboard: every strobe accepted at a rising edge is checked at the following falling edge
  always @(posedge clk) vld_at_edge <= ifc.st_vld && rst_n;

  always @(negedge clk) begin
    if (vld_at_edge) begin
      if (exp_q.size() == 0) begin
        check("st_queue_underflow", 32'd1, 32'd0);
      end else begin
        check("st_avg", 32'(ifc.ST), 32'(exp_q.pop_front()));
        check("st_ready_after_vld", 32'(ifc.st_ready), 32'd1);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.raw_fd = 1'b1;
    ifc.raw_rd = 1'b1;
    ifc.raw_w  = 1'b1;
    ifc.raw_fa = 1'b1;
    ifc.st_raw = 7'd99;
    ifc.st_vld = 1'b0;
    rst_n      = 1'b0;

    // Reset held with contacts high and strobes pulsing: outputs must stay at reset values.
    for (int c = 0; c < 8; c++) begin
      ifc.st_vld = c[0];
      tick();
      check("reset_hold", {27'd0, ifc.SFD, ifc.SRD, ifc.SW, ifc.SFA, ifc.st_ready},
            32'd0);
      check("reset_st", 32'(ifc.ST), 32'd25);
    end
    ifc.st_vld = 1'b0;
    ifc.raw_fd = 1'b0;
    ifc.raw_rd = 1'b0;
    ifc.raw_w  = 1'b0;
    ifc.raw_fa = 1'b0;
    rst_n = 1'b1;
    idle(3);
    check("post_reset_st", 32'(ifc.ST), 32'd25);
    check("post_reset_ready", 32'(ifc.st_ready), 32'd0);

    // Glitch shorter than the debounce window never reaches SFD.
    ifc.raw_fd = 1'b1;
    idle(10);
    ifc.raw_fd = 1'b0;
    for (int e = 0; e < 30; e++) begin
      tick();
      check("glitch_sfd", 32'(ifc.SFD), 32'd0);
    end

    // Front door and fire alarm rise together: N+2 edges each.
    ifc.raw_fd = 1'b1;
    ifc.raw_fa = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      check("rise_sfa", 32'(ifc.SFA), 32'(e >= FA + 2));
      check("rise_sfd", 32'(ifc.SFD), 32'(e >= DEB + 2));
    end
    ifc.raw_fd = 1'b0;
    ifc.raw_fa = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      check("fall_sfa", 32'(ifc.SFA), 32'(e < FA + 2));
      check("fall_sfd", 32'(ifc.SFD), 32'(e < DEB + 2));
    end

    // A one-cycle dropout inside the window restarts the count.
    ifc.raw_w = 1'b1;
    idle(14);
    ifc.raw_w = 1'b0;
    tick();
    ifc.raw_w = 1'b1;
    for (int e = 1; e <= 18; e++) begin
      tick();
      check("restart_sw", 32'(ifc.SW), 32'(e >= DEB + 2));
    end

    // Reset in the middle of a rear-door debounce abandons it.
    ifc.raw_rd = 1'b1;
    idle(12);
    rst_n = 1'b0;
    tick();
    check("midrst_srd", 32'(ifc.SRD), 32'd0);
    check("midrst_sw", 32'(ifc.SW), 32'd0);
    rst_n = 1'b1;
    mdl_prime = 1'b0;
    for (int e = 1; e <= 18; e++) begin
      tick();
      check("midrst_srd_rise", 32'(ifc.SRD), 32'(e >= DEB + 2));
    end
    check("midrst_st", 32'(ifc.ST), 32'd25);
    check("midrst_ready", 32'(ifc.st_ready), 32'd0);

    // Prime, then back-to-back strobes: 20 -> 25, 30, 35, 40.
    send_temp(7'd20);
    for (int i = 0; i < 4; i++) send_temp(7'd40);
    idle(2);

    // Floor: 20,21,21,21 -> 83 >> 2 = 20, then the value holds with no strobes.
    send_temp(7'd20);
    idle(1);
    send_temp(7'd21);
    send_temp(7'd21);
    idle(2);
    send_temp(7'd21);
    idle(1);
    check("floor_st", 32'(ifc.ST), 32'd20);
    for (int c = 0; c < 100; c++) begin
      tick();
      if (c % 25 == 24) check("hold_st", 32'(ifc.ST), 32'd20);
    end

    // Random samples with random gaps, including consecutive strobes.
    for (int i = 0; i < 40; i++) begin
      send_temp(7'($urandom_range(0, 127)));
      idle($urandom_range(0, 2));
    end

    // Drain the scoreboard within a bounded number of cycles.
    for (int c = 0; c < 10 && exp_q.size() != 0; c++) tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
